mem_port_arbiter: RTL

Round-robin arbiter and sequencer for the shared 32-bit memory port in the CPU. Up to four requesters (instruction fetch, load/store, DMA, debug) compete for the port. The block grants one requester at a time, holds the grant until the transaction completes, and drives the select input of the 4-to-1 mux that routes the winner's address and write data onto the port. An optional hold-timeout watchdog force-releases a grant that never completes.

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared 32-bit memory port (4 requesters).
// Optional hold-timeout watchdog is enabled by defining MEM_ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       xfer_done,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] select_q, select_d;
    logic [3:0] grant_q, grant_d;
    logic       busy_q, busy_d;

    logic       found;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       hold_expired;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    assign hold_expired = (hold_q == HOLD_LAST);

    // Counter restarts every grant; only the third release reason raises timeout.
    always_comb begin
        hold_d    = '0;
        timeout_d = 1'b0;
        if (state_q == BUSY) begin
            hold_d    = hold_q + 8'd1;
            timeout_d = !xfer_done && req[select_q] && hold_expired;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    localparam int unused_max_hold = MAX_HOLD;

    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    // Rotating search starting at ptr; first set request wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        select_d = select_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = 4'b0001 << pick;
                    select_d = pick;
                    busy_d   = 1'b1;
                    ptr_d    = pick + 2'd1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // select and ptr deliberately survive release so the mux stays quiet.
                if (xfer_done || !req[select_q] || hold_expired) begin
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            select_q <= 2'd0;
            grant_q  <= 4'b0000;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            select_q <= select_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    assign grant  = grant_q;
    assign select = select_q;
    assign busy   = busy_q;

endmodule
